// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: FSM state codes and ALU select codes.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HAVE_A  = 3'd1,
    S_HAVE_B  = 3'd2,
    S_EXEC    = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_ADD2    = 3'd1;
  localparam logic [2:0] OP_XOR_OR  = 3'd2;
  localparam logic [2:0] OP_RED_OR  = 3'd3;
  localparam logic [2:0] OP_RED_AND = 3'd4;
  localparam logic [2:0] OP_SWAP    = 3'd5;
  localparam logic [2:0] OP_ZERO    = 3'd6;
  localparam logic [2:0] OP_ZERO2   = 3'd7;

endpackage

// File: rtl/alu_sequencer.sv
// Sequences two operand loads and an op select into an external combinational ALU,
// then captures its result; latency go->done is 3 cycles, strobes are dropped while busy.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int RES_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic [2:0]        op,
  input  logic              go,
  input  logic              chain,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [RES_W-1:0]  alu_result,
  output logic [RES_W-1:0]  result,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  state_t            state, nxt;
  logic [DATA_W-1:0] reg_a, reg_b;
  logic [2:0]        reg_op;
  logic              set_a, set_b, set_op, set_res, set_chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      reg_a  <= '0;
      reg_b  <= '0;
      reg_op <= '0;
      result <= '0;
    end else begin
      state <= nxt;
      if (set_a)     reg_a  <= data_in;
      if (set_chain) reg_a  <= result[DATA_W-1:0];
      if (set_b)     reg_b  <= data_in;
      if (set_op)    reg_op <= op;
      if (set_res)   result <= alu_result;
    end
  end

  always_comb begin
    nxt       = state;
    set_a     = 1'b0;
    set_b     = 1'b0;
    set_op    = 1'b0;
    set_res   = 1'b0;
    set_chain = 1'b0;
    case (state)
      S_IDLE: begin
        if (load) begin
          set_a = 1'b1;
          nxt   = S_HAVE_A;
        end
      end
      S_HAVE_A: begin
        if (load) begin
          set_b = 1'b1;
          nxt   = S_HAVE_B;
        end
      end
      S_HAVE_B: begin
        // go has priority so a coincident load cannot disturb the operand being executed
        if (go) begin
          set_op = 1'b1;
          nxt    = S_EXEC;
        end else if (load) begin
          set_b = 1'b1;
        end
      end
      S_EXEC:    nxt = S_CAPTURE;
      S_CAPTURE: begin
        set_res = 1'b1;
        nxt     = S_DONE;
      end
      S_DONE: begin
        if (chain) begin
          set_chain = 1'b1;
          nxt       = S_HAVE_A;
        end else begin
          nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign alu_a     = reg_a;
  assign alu_b     = reg_b;
  assign alu_sel   = reg_op;
  assign busy      = (state == S_EXEC) || (state == S_CAPTURE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small behavioural ALU beside it.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] data_in;
  logic       load, go, chain;
  logic [2:0] op;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic [7:0] result;
  logic       busy, done;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(4), .RES_W(8)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .op(op), .go(go),
    .chain(chain), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .result(result), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  always_comb begin
    alu_result = 8'h00;
    case (alu_sel)
      3'd0: alu_result = {4'h0, alu_a} + {4'h0, alu_b};
      3'd2: alu_result = {alu_a ^ alu_b, alu_a | alu_b};
      3'd5: alu_result = {alu_b, alu_a};
      default: alu_result = 8'h00;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] v);
    data_in = v;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; data_in = 4'h0; load = 1'b0; go = 1'b0; chain = 1'b0; op = 3'd0;
    step(); step();
    reset = 1'b0;
    chk("rst_state", {5'd0, state_dbg}, 8'h00);
    chk("rst_result", result, 8'h00);
    chk("rst_done", {7'd0, done}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_ab", {alu_a, alu_b}, 8'h00);
    chk("rst_sel", {5'd0, alu_sel}, 8'h00);

    // Basic add 3+5
    go = 1'b1; step(); go = 1'b0;
    chk("idle_go_ignored", {5'd0, state_dbg}, 8'h00);
    do_load(4'h3);
    chk("have_a_state", {5'd0, state_dbg}, 8'h01);
    chk("have_a_a", {4'h0, alu_a}, 8'h03);
    do_load(4'h5);
    chk("have_b_state", {5'd0, state_dbg}, 8'h02);
    chk("have_b_b", {4'h0, alu_b}, 8'h05);
    op = 3'd0; go = 1'b1; step(); go = 1'b0;
    chk("exec_state", {5'd0, state_dbg}, 8'h03);
    chk("exec_busy", {7'd0, busy}, 8'h01);
    chk("exec_done", {7'd0, done}, 8'h00);
    step();
    chk("cap_state", {5'd0, state_dbg}, 8'h04);
    chk("cap_busy", {7'd0, busy}, 8'h01);
    chk("cap_done", {7'd0, done}, 8'h00);
    step();
    chk("add_done", {7'd0, done}, 8'h01);
    chk("add_busy", {7'd0, busy}, 8'h00);
    chk("add_result", result, 8'h08);
    step();
    chk("add_back_idle", {5'd0, state_dbg}, 8'h00);
    chk("add_done_clr", {7'd0, done}, 8'h00);
    chk("add_result_hold", result, 8'h08);

    // Carry F+F
    do_load(4'hF); do_load(4'hF);
    go = 1'b1; step(); go = 1'b0;
    step(); step();
    chk("carry_done", {7'd0, done}, 8'h01);
    chk("carry_result", result, 8'h1E);
    step();

    // Chain: 9+9 then (2)+1
    chain = 1'b1;
    do_load(4'h9); do_load(4'h9);
    go = 1'b1; step(); go = 1'b0;
    step(); step();
    chk("chain1_result", result, 8'h12);
    step();
    chk("chain_state", {5'd0, state_dbg}, 8'h01);
    chk("chain_a", {4'h0, alu_a}, 8'h02);
    do_load(4'h1);
    go = 1'b1; step(); go = 1'b0;
    step(); step();
    chk("chain2_result", result, 8'h03);
    chain = 1'b0;
    step();
    chk("chain_exit_idle", {5'd0, state_dbg}, 8'h00);

    // Simultaneous load+go in HAVE_B, strobes ignored while busy
    do_load(4'h6); do_load(4'h4);
    data_in = 4'h7; load = 1'b1; go = 1'b1; op = 3'd0;
    step();
    chk("ldgo_state", {5'd0, state_dbg}, 8'h03);
    chk("ldgo_b", {4'h0, alu_b}, 8'h04);
    data_in = 4'hE; op = 3'd5;
    step();
    chk("exec_strobe_state", {5'd0, state_dbg}, 8'h04);
    chk("exec_strobe_sel", {5'd0, alu_sel}, 8'h00);
    load = 1'b0; go = 1'b0;
    step();
    chk("ldgo_done", {7'd0, done}, 8'h01);
    chk("ldgo_result", result, 8'h0A);
    load = 1'b1; go = 1'b1;
    step();
    load = 1'b0; go = 1'b0;
    chk("done_strobe_state", {5'd0, state_dbg}, 8'h00);
    chk("done_strobe_a", {4'h0, alu_a}, 8'h06);
    chk("single_done", {7'd0, done}, 8'h00);
    step();
    chk("no_second_done", {7'd0, done}, 8'h00);
    chk("still_idle", {5'd0, state_dbg}, 8'h00);

    // Swap op: result {b,a}
    do_load(4'h2); do_load(4'h3);
    op = 3'd5; go = 1'b1; step(); go = 1'b0; op = 3'd0;
    chk("swap_sel", {5'd0, alu_sel}, 8'h05);
    step(); step();
    chk("swap_result", result, 8'h32);
    step();

    // Reset during CAPTURE
    do_load(4'h2); do_load(4'h3);
    op = 3'd0; go = 1'b1; step(); go = 1'b0;
    step();
    chk("pre_rst_cap", {5'd0, state_dbg}, 8'h04);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_state", {5'd0, state_dbg}, 8'h00);
    chk("midrst_result", result, 8'h00);
    chk("midrst_done", {7'd0, done}, 8'h00);
    chk("midrst_regs", {alu_a, alu_b}, 8'h00);
    step();
    chk("midrst_stays_idle", {5'd0, state_dbg}, 8'h00);
    chk("midrst_result_hold", result, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
